uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter between several byte producers on the clock board. It runs the `startTransmission`/`done` handshake of the transmitter and latches the winning requester's byte. It acknowledges each accepted byte and returns to arbitration only after the transmitter reports the stop bit complete. It sits between the producers (time formatter, debug dump, etc.) and the single UART TX path to the board's serial pin.

## Interface
Parameters:
- NrOfRequesters, 4: number of producers; legal range 2..8.
- NrOfDataBits, 8: byte width; must match the transmitter.
- DoneTimeout, 16: cycles allowed for `uartDone` to fall after a start pulse.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- req  input  NrOfRequesters  per-requester request; held high until the matching `ack`.
- data  input  NrOfRequesters*NrOfDataBits  flattened bytes; requester i occupies bits [i*NrOfDataBits +: NrOfDataBits].
- ack  output  NrOfRequesters  one-hot, one-cycle pulse when the requester's byte is latched.
- busy  output  1  high whenever the state is not IDLE.
- error  output  1  sticky; set on done timeout; cleared only by reset.
- uartStart  output  1  one-cycle start pulse to the transmitter.
- uartData  output  NrOfDataBits  latched byte to the transmitter; stable from the start pulse until the frame completes.
- uartDone  input  1  transmitter done level. It falls after a start is accepted and rises after the stop bit.

## Operation
- States:
  - IDLE: waiting for any request.
  - START: start pulse issued.
  - WAIT_LOW: waiting for `uartDone` to fall.
  - WAIT_HIGH: waiting for `uartDone` to rise.
- IDLE, with any `req` high:
  - Grant goes to the first requester with `req` high, searching from `last+1` upward and wrapping from N-1 to 0.
  - `last` is the previously granted index.
  - On the same edge: latch that requester's byte into `uartData`, set `ack[g]`=1, set `last`=g, and go to START.
- IDLE, with no request: stay in IDLE; `last` is unchanged.
- START: drive `uartStart`=1 for this cycle only, clear the timeout counter, and go to WAIT_LOW.
- WAIT_LOW:
  - If `uartDone`=0, go to WAIT_HIGH.
  - Otherwise increment the counter.
  - If the counter reaches DoneTimeout-1 with `uartDone` still 1: set `error`, return to IDLE, and drop the byte (no re-send).
- WAIT_HIGH: when `uartDone`=1, go to IDLE.
  - There is no timeout in WAIT_HIGH.
  - Frame length is set by the transmitter's baud rate.
- `uartDone` is never sampled outside WAIT_LOW and WAIT_HIGH. This makes its undefined level after transmitter reset irrelevant.
- Requester rule: drop `req` or present a new byte on the cycle after `ack`.
  - A `req` still high while the FSM is in START, WAIT_LOW or WAIT_HIGH is not re-granted.
  - In IDLE it is treated as a new byte.
- `data` is sampled only on the grant edge. Changes at any other time have no effect.
- Pointer width is clog2(NrOfRequesters). The wrap is explicit, so non-power-of-two counts never select an index ≥ N.

## Timing
- Reset values (reset low at a clock edge):
  - state=IDLE, `ack`=0, `busy`=0, `error`=0, `uartStart`=0, `uartData`=0.
  - Counter=0, `last`=N-1, so requester 0 has first priority.
- Reset mid-frame: the FSM returns to IDLE and the frame is abandoned. The transmitter is reset separately by the top level.
- Latency:
  - `req` sampled high in IDLE at edge k: `ack` and latched `uartData` are visible after edge k.
  - `uartStart` is high between edges k+1 and k+2.
  - `busy` rises after edge k.
- Back-to-back: `busy` falls the cycle after `uartDone` is sampled high in WAIT_HIGH. The next grant can occur on the following edge, so the gap is ≥ 1 idle cycle between frames.
- Simultaneous requests: exactly one grant per frame. A requester with `req` held continuously is served at most once per N frames while others are waiting.
- `ack` is never asserted outside the IDLE→START transition. `uartStart` is never asserted outside START.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with all `req`=1. Required: `ack`=0, `uartStart`=0, `busy`=0, `error`=0, `uartData`=0. After release, the first grant goes to requester 0.
- Single byte:
  - Stimulus: `req[2]`=1 with byte 0x41; a transmitter model drops done 1 cycle after start and raises it 100 cycles later.
  - Required: `ack`=4'b0100 for one cycle, `uartData`=0x41, one `uartStart` pulse, `busy` high until done rises.
- Round-robin: all four `req` held high with bytes 0x10, 0x11, 0x12, 0x13. Required grant order 0,1,2,3,0 across five frames. `uartData` sequence 0x10, 0x11, 0x12, 0x13, 0x10.
- Wrap / fairness: `last`=3, then `req`=4'b1001. Required: grant to 0, then 3.
- Timeout: the transmitter model never drops done. Required: `error`=1 exactly 16 cycles after the start pulse, FSM back in IDLE, and the next `req` is still served.
- Mid-frame reset: assert reset during WAIT_HIGH. Required: all outputs at reset values on the next edge, and no `ack` or `uartStart` until a new request.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between several byte producers.
// Runs the start/done handshake, latches the granted byte and flags a sticky done timeout.
module uart_tx_arbiter #(
  parameter int NrOfRequesters = 4,
  parameter int NrOfDataBits   = 8,
  parameter int DoneTimeout    = 16
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic [NrOfRequesters-1:0]                req,
  input  logic [NrOfRequesters*NrOfDataBits-1:0]   data,
  output logic [NrOfRequesters-1:0]                ack,
  output logic                                     busy,
  output logic                                     error,
  output logic                                     uartStart,
  output logic [NrOfDataBits-1:0]                  uartData,
  input  logic                                     uartDone
);

  localparam int PtrW  = (NrOfRequesters > 2) ? $clog2(NrOfRequesters) : 1;
  localparam int CandW = PtrW + 1;
  localparam int CntW  = (DoneTimeout > 2) ? $clog2(DoneTimeout) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWaitLow,
    StWaitHigh
  } state_e;

  state_e                    r_state, w_state_next;
  logic [PtrW-1:0]           r_last, w_last_next;
  logic [CntW-1:0]           r_cnt, w_cnt_next;
  logic [NrOfRequesters-1:0] r_ack, w_ack_next;
  logic                      r_start, w_start_next;
  logic                      r_error, w_error_next;
  logic [NrOfDataBits-1:0]   r_data, w_data_next;

  logic                      w_found;
  logic [PtrW-1:0]           w_grant;
  logic [CandW-1:0]          w_cand;
  logic [NrOfDataBits-1:0]   w_bytes [NrOfRequesters];

  for (genvar i = 0; i < NrOfRequesters; i++) begin : g_unpack
    assign w_bytes[i] = data[i*NrOfDataBits +: NrOfDataBits];
  end

  // Search last+1 upward with an explicit wrap so no index >= NrOfRequesters is produced.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_cand  = '0;
    for (int off = 1; off <= NrOfRequesters; off++) begin
      w_cand = {1'b0, r_last} + CandW'(off);
      if (w_cand >= CandW'(NrOfRequesters)) begin
        w_cand = w_cand - CandW'(NrOfRequesters);
      end
      if (!w_found && req[w_cand[PtrW-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_cand[PtrW-1:0];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_last_next  = r_last;
    w_cnt_next   = r_cnt;
    w_ack_next   = '0;
    w_start_next = 1'b0;
    w_error_next = r_error;
    w_data_next  = r_data;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_data_next         = w_bytes[w_grant];
          w_ack_next[w_grant] = 1'b1;
          w_last_next         = w_grant;
          w_state_next        = StStart;
        end
      end
      StStart: begin
        w_start_next = 1'b1;
        w_cnt_next   = '0;
        w_state_next = StWaitLow;
      end
      StWaitLow: begin
        if (!uartDone) begin
          w_state_next = StWaitHigh;
        end else if (r_cnt == CntW'(DoneTimeout - 1)) begin
          // Transmitter never accepted the start: drop the byte and flag it.
          w_error_next = 1'b1;
          w_state_next = StIdle;
        end else begin
          w_cnt_next = r_cnt + CntW'(1);
        end
      end
      StWaitHigh: begin
        if (uartDone) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= StIdle;
      r_last  <= PtrW'(NrOfRequesters - 1);
      r_cnt   <= '0;
      r_ack   <= '0;
      r_start <= 1'b0;
      r_error <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      r_last  <= w_last_next;
      r_cnt   <= w_cnt_next;
      r_ack   <= w_ack_next;
      r_start <= w_start_next;
      r_error <= w_error_next;
      r_data  <= w_data_next;
    end
  end

  assign ack       = r_ack;
  assign busy      = (r_state != StIdle);
  assign error     = r_error;
  assign uartStart = r_start;
  assign uartData  = r_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a transmitter model and a round-robin
// reference model that picks the first requester after the last grant.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   ack;
  logic           busy;
  logic           error;
  logic           uartStart;
  logic [W-1:0]   uartData;
  logic           uartDone;

  int n_tests = 0;
  int n_fail  = 0;
  int m_last  = N - 1;
  int tx_len  = 5;
  bit tx_stuck = 1'b0;
  int tx_cnt  = 0;

  always #5 clock = ~clock;

  uart_tx_arbiter #(
    .NrOfRequesters(N),
    .NrOfDataBits  (W),
    .DoneTimeout   (TO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .data     (data),
    .ack      (ack),
    .busy     (busy),
    .error    (error),
    .uartStart(uartStart),
    .uartData (uartData),
    .uartDone (uartDone)
  );

  // Transmitter: done falls one cycle after the start pulse, rises tx_len cycles later.
  always @(posedge clock) begin
    if (!reset) begin
      uartDone <= 1'b1;
      tx_cnt   <= 0;
    end else if (uartStart && !tx_stuck) begin
      uartDone <= 1'b0;
      tx_cnt   <= tx_len;
    end else if (tx_cnt > 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) uartDone <= 1'b1;
    end
  end

  function automatic int rr_pick(input int last, input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++) begin
      if (mask[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset  = 1'b1;
    m_last = N - 1;
  endtask

  // Runs one request through a full frame and reports what was observed.
  task automatic do_frame(input logic [N-1:0] mask, input logic [N*W-1:0] bytes, input bit hold,
                          output logic [N-1:0] o_ack, output logic [W-1:0] o_data,
                          output int o_starts, output int o_acks, output int o_busy,
                          output bit o_stable, output bit o_ok);
    req      = mask;
    data     = bytes;
    o_ack    = '0;
    o_data   = '0;
    o_starts = 0;
    o_acks   = 0;
    o_busy   = 0;
    o_stable = 1'b1;
    o_ok     = 1'b0;
    for (int i = 0; i < 20 && !o_ok; i++) begin
      @(negedge clock);
      if (ack != '0) begin
        o_ack  = ack;
        o_data = uartData;
        o_acks = 1;
        o_busy = busy ? 1 : 0;
        o_ok   = 1'b1;
      end
    end
    if (o_ok) begin
      if (!hold) req = req & ~o_ack;
      data = 32'($urandom);
      o_ok = 1'b0;
      for (int i = 0; i < 1000 && !o_ok; i++) begin
        @(negedge clock);
        if (uartStart) o_starts++;
        if (ack != '0) o_acks++;
        if (busy) begin
          o_busy++;
          if (uartData !== o_data) o_stable = 1'b0;
        end else begin
          o_ok = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [N-1:0] a;
    logic [W-1:0] d;
    int s, c, b;
    bit st, ok;
    reset = 1'b0;
    req   = '1;
    data  = 32'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_tests++;
      if ({ack, uartStart, busy, error, uartData} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: ack=%b start=%b busy=%b error=%b data=%h, all zero required",
                 ack, uartStart, busy, error, uartData);
      end
    end
    reset  = 1'b1;
    m_last = N - 1;
    do_frame(4'b1111, 32'h4433_2211, 1'b0, a, d, s, c, b, st, ok);
    n_tests++;
    if (!ok || a !== 4'b0001 || d !== 8'h11) begin
      n_fail++;
      $display("FAIL reset_first_grant: ok=%0d ack=%b data=%h, required ack=0001 data=11",
               ok, a, d);
    end
    m_last = 0;
    req = '0;
  endtask

  task automatic test_single();
    logic [N-1:0] a;
    logic [W-1:0] d;
    int s, c, b;
    bit st, ok;
    tx_len = 100;
    do_frame(4'b0100, 32'hAA41_BBCC, 1'b0, a, d, s, c, b, st, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL single_done: frame did not complete, completion required"); end
    n_tests++;
    if (a !== 4'b0100) begin n_fail++; $display("FAIL single_ack: got %b expected 0100", a); end
    n_tests++;
    if (d !== 8'h41) begin n_fail++; $display("FAIL single_data: got %h expected 41", d); end
    n_tests++;
    if (s != 1 || c != 1) begin
      n_fail++;
      $display("FAIL single_pulses: starts=%0d acks=%0d expected 1 and 1", s, c);
    end
    n_tests++;
    if (b != tx_len + 3) begin
      n_fail++;
      $display("FAIL single_busy_len: got %0d cycles expected %0d", b, tx_len + 3);
    end
    n_tests++;
    if (!st) begin n_fail++; $display("FAIL single_data_stable: uartData changed mid-frame, stable required"); end
    m_last = 2;
    req = '0;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] a;
    logic [W-1:0] d;
    int s, c, b, e;
    bit st, ok;
    do_reset();
    tx_len = 4;
    for (int f = 0; f < 5; f++) begin
      e = rr_pick(m_last, 4'b1111);
      do_frame(4'b1111, 32'h1312_1110, 1'b1, a, d, s, c, b, st, ok);
      n_tests++;
      if (!ok || a !== (4'b0001 << e) || d !== 8'(8'h10 + e) || s != 1 || c != 1) begin
        n_fail++;
        $display("FAIL rr_frame%0d: ok=%0d ack=%b data=%h starts=%0d acks=%0d, expected grant %0d data %h",
                 f, ok, a, d, s, c, e, 8'(8'h10 + e));
      end
      m_last = e;
    end
    req = '0;
  endtask

  task automatic test_wrap();
    logic [N-1:0] a;
    logic [W-1:0] d;
    int s, c, b;
    bit st, ok;
    do_reset();
    tx_len = 3;
    do_frame(4'b1000, 32'hD3C2_B1A0, 1'b0, a, d, s, c, b, st, ok);
    n_tests++;
    if (!ok || a !== 4'b1000) begin n_fail++; $display("FAIL wrap_setup: ack=%b expected 1000", a); end
    do_frame(4'b1001, 32'hD3C2_B1A0, 1'b1, a, d, s, c, b, st, ok);
    n_tests++;
    if (!ok || a !== 4'b0001 || d !== 8'hA0) begin
      n_fail++;
      $display("FAIL wrap_to_0: ack=%b data=%h expected 0001 a0", a, d);
    end
    do_frame(4'b1001, 32'hD3C2_B1A0, 1'b0, a, d, s, c, b, st, ok);
    n_tests++;
    if (!ok || a !== 4'b1000 || d !== 8'hD3) begin
      n_fail++;
      $display("FAIL wrap_to_3: ack=%b data=%h expected 1000 d3", a, d);
    end
    m_last = 3;
    req = '0;
  endtask

  task automatic test_timeout();
    logic [N-1:0] a;
    logic [W-1:0] d;
    int s, c, b, cnt, e;
    bit st, ok, got;
    tx_stuck = 1'b1;
    e = rr_pick(m_last, 4'b0010);
    req  = 4'b0010;
    data = 32'($urandom);
    ok   = 1'b0;
    a    = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      if (ack != '0) begin ok = 1'b1; a = ack; end
    end
    req = '0;
    n_tests++;
    if (!ok || a !== (4'b0001 << e)) begin
      n_fail++;
      $display("FAIL timeout_ack: ok=%0d ack=%b expected %b", ok, a, 4'b0001 << e);
    end
    m_last = e;
    ok = 1'b0;
    for (int i = 0; i < 5 && !ok; i++) begin
      @(negedge clock);
      if (uartStart) ok = 1'b1;
    end
    cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      cnt++;
      if (error) got = 1'b1;
    end
    n_tests++;
    if (!ok || !got || cnt != TO) begin
      n_fail++;
      $display("FAIL timeout_latency: start_seen=%0d error_seen=%0d cycles=%0d expected %0d",
               ok, got, cnt, TO);
    end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: busy=%b expected 0", busy); end
    tx_stuck = 1'b0;
    tx_len   = 6;
    e = rr_pick(m_last, 4'b0100);
    do_frame(4'b0100, 32'h0055_0000, 1'b0, a, d, s, c, b, st, ok);
    n_tests++;
    if (!ok || a !== (4'b0001 << e) || d !== 8'h55 || error !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_recover: ok=%0d ack=%b data=%h error=%b expected %b 55 1",
               ok, a, d, error, 4'b0001 << e);
    end
    m_last = e;
    req = '0;
  endtask

  task automatic test_mid_reset();
    logic [N-1:0] a;
    logic [W-1:0] d;
    int s, c, b;
    bit st, ok, bad;
    tx_len = 50;
    req  = 4'b1000;
    data = 32'h7700_0000;
    ok   = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      if (ack != '0) ok = 1'b1;
    end
    req = '0;
    for (int i = 0; i < 10; i++) @(negedge clock);
    n_tests++;
    if (!ok || busy !== 1'b1 || uartDone !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_setup: ok=%0d busy=%b done=%b expected 1 1 0", ok, busy, uartDone);
    end
    reset = 1'b0;
    @(negedge clock);
    n_tests++;
    if ({ack, uartStart, busy, error, uartData} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: ack=%b start=%b busy=%b error=%b data=%h, all zero required",
               ack, uartStart, busy, error, uartData);
    end
    reset  = 1'b1;
    m_last = N - 1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (ack != '0 || uartStart || busy) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL midreset_quiet: activity seen without request, none required"); end
    tx_len = 4;
    do_frame(4'b1001, 32'h9900_0088, 1'b0, a, d, s, c, b, st, ok);
    n_tests++;
    if (!ok || a !== 4'b0001 || d !== 8'h88) begin
      n_fail++;
      $display("FAIL midreset_regrant: ack=%b data=%h expected 0001 88", a, d);
    end
    m_last = 0;
    req = '0;
  endtask

  task automatic test_random();
    logic [N-1:0]   a, mask;
    logic [W-1:0]   d;
    logic [N*W-1:0] bytes;
    int s, c, b, e;
    bit st, ok, hold;
    for (int f = 0; f < 30; f++) begin
      mask   = 4'($urandom_range(1, 15));
      bytes  = 32'($urandom);
      hold   = 1'($urandom_range(0, 1));
      tx_len = int'($urandom_range(1, 20));
      e = rr_pick(m_last, mask);
      do_frame(mask, bytes, hold, a, d, s, c, b, st, ok);
      n_tests++;
      if (!ok || a !== (4'b0001 << e) || d !== bytes[e*W +: W]) begin
        n_fail++;
        $display("FAIL rand%0d_grant: mask=%b ok=%0d ack=%b data=%h expected %b %h",
                 f, mask, ok, a, d, 4'b0001 << e, bytes[e*W +: W]);
      end
      n_tests++;
      if (s != 1 || c != 1 || !st || b != tx_len + 3) begin
        n_fail++;
        $display("FAIL rand%0d_frame: starts=%0d acks=%0d stable=%0d busy=%0d expected 1 1 1 %0d",
                 f, s, c, st, b, tx_len + 3);
      end
      m_last = e;
    end
    req = '0;
  endtask

  initial begin
    reset = 1'b0;
    req   = '0;
    data  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, finish required");
    $fatal(1);
  end

endmodule
